m_seq_checker: RTL and testbench
================================

Name: m_seq_checker

Overview:
- Receive-side counterpart of the bitstream source: consumes 2- or 4-bit symbols (the output of the serial-to-parallel stage or of a demapper) and restores serial bit order.
- Self-synchronises a local LFSR to the incoming m-sequence, then counts bit errors.
- Sits at the end of the loopback/BER test path and reports lock status, bit count and error count.

Parameters:
- REG_LEN, 13, LFSR length; must equal the generator's REG_LEN.
- TAP_MASK, 13'h1B00, bit k-1 set means b[n-k] feeds the recurrence; default encodes b[n]=b[n-9]^b[n-10]^b[n-12]^b[n-13] (x^13+x^4+x^3+x+1).
- LOCK_MATCH, 32, consecutive correct predictions required to lock.
- WIN_LEN, 256, loss-of-lock window in bits; must be a multiple of 4.
- LOSS_THRESH, 32, errors within one window that force loss of lock.
- CNT_W, 32, width of bit_count and err_count.

Ports:
- clk  in  1  symbol-rate domain clock
- rst  in  1  asynchronous active-high reset
- mod_type  in  1  1 = 4 bits/symbol (16QAM), 0 = 2 bits/symbol (QPSK)
- sym_in  in  4  received symbol; in QPSK only [1:0] are used
- sym_valid  in  1  sym_in is valid this cycle
- clr_cnt  in  1  synchronous clear of bit_count and err_count
- locked  out  1  checker in LOCK state
- lock_lost  out  1  one-cycle pulse on LOCK to SEARCH transition
- bit_err  out  3  errors detected in the last processed symbol (0..4)
- bit_count  out  CNT_W  bits checked while locked, saturating
- err_count  out  CNT_W  bit errors while locked, saturating

Behaviour:
- Reset: state SEARCH; history register, fill_cnt, match_cnt, win_bits and win_errs all 0; every output 0.
- Nothing advances when sym_valid=0. clr_cnt still acts; bit_err and lock_lost are forced to 0.
- Bit order:
  - mod_type=1: sym_in[3], [2], [1], [0], earliest bit first.
  - mod_type=0: sym_in[1], then [0].
  - mod_type is sampled per valid cycle; a change never forces resync.
- All bits of one symbol are processed in a single cycle (unrolled 2 or 4 LFSR steps).
- The state used is fixed for the whole symbol; any state change takes effect on the next valid symbol.
- Prediction: pred = XOR of history taps per TAP_MASK.
- SEARCH, per bit:
  - If fill_cnt<REG_LEN: shift the received bit in and increment fill_cnt; no compare.
  - Else if history is all zero: match_cnt=0.
  - Else: match increments match_cnt (saturating at LOCK_MATCH); mismatch clears it.
  - The received bit is always shifted in (self-synchronising).
- SEARCH end of symbol: if match_cnt>=LOCK_MATCH, go to LOCK; clear win_bits and win_errs.
- LOCK, per bit:
  - History shifts in pred (free-running), so a single channel error counts once.
  - error = received XOR pred.
  - Increment bit_count, err_count, win_bits and win_errs.
- LOCK end of symbol:
  - If win_bits>=WIN_LEN: if win_errs>=LOSS_THRESH, go to SEARCH, clear fill_cnt and match_cnt, pulse lock_lost. Otherwise clear win_bits and win_errs and stay locked.
- Counters: add 0..4 per cycle, saturating at all-ones.
- clr_cnt=1 zeroes both counters and takes priority over an increment in the same cycle.
- bit_err: registered error count for the last valid symbol processed in LOCK; 0 in SEARCH.
- Latency: all outputs are registered and update on the clk edge of the valid cycle that causes them. locked rises on the edge of the symbol completing the LOCK_MATCH-th match.
- Async reset mid-operation: immediate return to reset values; lock is reacquired from an empty history.

Test Plan:
- Clean 16QAM PRBS13, 1 symbol every cycle -> locked=1 after the 12th valid symbol (4*12-13=35>=32 matches); err_count stays 0; bit_count=400 after 100 more symbols.
- Clean QPSK PRBS13 -> locked after the 23rd valid symbol; bit_err always 0.
- Locked, one bit flipped in one symbol -> bit_err=1 for that cycle; err_count increments by exactly 1; locked stays 1.
- Locked, invert every bit for 64 symbols (16QAM) -> lock_lost pulses once at the next window boundary, locked=0; after clean data resumes, relock within 12 symbols.
- All-zero sym_in for 1000 symbols -> locked never asserts; counters stay 0.
- Error coincident with clr_cnt=1 -> err_count=0 and bit_count=0 next cycle. rst pulse while locked -> all outputs 0 immediately.

Source files
------------

// File: rtl/m_seq_checker_if.sv
// Symbol input and status bundle between the BER test path and m_seq_checker.
// Handshake: sym_valid qualifies mod_type/sym_in for one cycle; there is no ready, the checker accepts every valid symbol.
interface m_seq_checker_if #(
  parameter int CNT_W = 32
);
  logic             mod_type;
  logic [3:0]       sym_in;
  logic             sym_valid;
  logic             clr_cnt;
  logic             locked;
  logic             lock_lost;
  logic [2:0]       bit_err;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;
  logic             state_dbg;

  modport master (
    output mod_type, sym_in, sym_valid, clr_cnt,
    input  locked, lock_lost, bit_err, bit_count, err_count, state_dbg
  );

  modport slave (
    input  mod_type, sym_in, sym_valid, clr_cnt,
    output locked, lock_lost, bit_err, bit_count, err_count, state_dbg
  );
endinterface

// File: rtl/m_seq_checker.sv
// Self-synchronising m-sequence checker: locks a local LFSR to received 2/4-bit symbols
// and counts bit errors while locked, with windowed loss-of-lock detection.
module m_seq_checker #(
  parameter int                 REG_LEN     = 13,
  parameter logic [REG_LEN-1:0] TAP_MASK    = 13'h1B00,
  parameter int                 LOCK_MATCH  = 32,
  parameter int                 WIN_LEN     = 256,
  parameter int                 LOSS_THRESH = 32,
  parameter int                 CNT_W       = 32
) (
  input logic            clk,
  input logic            rst,
  m_seq_checker_if.slave bus
);

  localparam int FILL_W  = $clog2(REG_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_MATCH + 1);
  localparam int WIN_W   = $clog2(WIN_LEN + 4) + 1;

  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(REG_LEN);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_MATCH);
  localparam logic [WIN_W-1:0]   WIN_FULL  = WIN_W'(WIN_LEN);
  localparam logic [WIN_W-1:0]   LOSS_MAX  = WIN_W'(LOSS_THRESH);

  typedef enum logic {S_SEARCH = 1'b0, S_LOCK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [REG_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   wbits_q, wbits_d;
  logic [WIN_W-1:0]   werrs_q, werrs_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   ecnt_q, ecnt_d;
  logic [2:0]         berr_q, berr_d;
  logic               lost_q, lost_d;

  logic [3:0]         rx_bits;
  logic [2:0]         nbits;
  logic [2:0]         sym_errs;
  logic [2:0]         inc_bits;
  logic               pred, rx, err;
  logic [CNT_W:0]     bsum, esum;

  // rx_bits[0] is the earliest bit on the wire
  assign rx_bits = bus.mod_type ? {bus.sym_in[0], bus.sym_in[1], bus.sym_in[2], bus.sym_in[3]}
                                : {2'b00, bus.sym_in[0], bus.sym_in[1]};
  assign nbits   = bus.mod_type ? 3'd4 : 3'd2;

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = match_q;
    wbits_d  = wbits_q;
    werrs_d  = werrs_q;
    berr_d   = 3'd0;
    lost_d   = 1'b0;
    sym_errs = 3'd0;
    pred     = 1'b0;
    rx       = 1'b0;
    err      = 1'b0;

    if (bus.sym_valid) begin
      for (int i = 0; i < 4; i++) begin
        if ((i < 2) || bus.mod_type) begin
          rx   = rx_bits[i];
          pred = ^(hist_d & TAP_MASK);
          if (state_q == S_SEARCH) begin
            if (fill_d < FILL_FULL) begin
              fill_d = fill_d + FILL_W'(1);
            end else if (hist_d == '0) begin
              match_d = '0;
            end else if (rx == pred) begin
              if (match_d < MATCH_MAX) match_d = match_d + MATCH_W'(1);
            end else begin
              match_d = '0;
            end
            hist_d = {hist_d[REG_LEN-2:0], rx};
          end else begin
            // Free-running in LOCK so a channel error is not re-predicted later
            err      = rx ^ pred;
            sym_errs = sym_errs + {2'b00, err};
            hist_d   = {hist_d[REG_LEN-2:0], pred};
          end
        end
      end

      if (state_q == S_SEARCH) begin
        if (match_d >= MATCH_MAX) begin
          state_d = S_LOCK;
          wbits_d = '0;
          werrs_d = '0;
        end
      end else begin
        berr_d  = sym_errs;
        wbits_d = wbits_q + WIN_W'(nbits);
        werrs_d = werrs_q + WIN_W'(sym_errs);
        if (wbits_d >= WIN_FULL) begin
          if (werrs_d >= LOSS_MAX) begin
            state_d = S_SEARCH;
            fill_d  = '0;
            match_d = '0;
            lost_d  = 1'b1;
          end else begin
            wbits_d = '0;
            werrs_d = '0;
          end
        end
      end
    end
  end

  assign inc_bits = (bus.sym_valid && (state_q == S_LOCK)) ? nbits : 3'd0;
  assign bsum     = {1'b0, bcnt_q} + {{(CNT_W-2){1'b0}}, inc_bits};
  assign esum     = {1'b0, ecnt_q} + {{(CNT_W-2){1'b0}}, sym_errs};

  always_comb begin
    bcnt_d = bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
    ecnt_d = esum[CNT_W] ? '1 : esum[CNT_W-1:0];
    if (bus.clr_cnt) begin
      bcnt_d = '0;
      ecnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_SEARCH;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      wbits_q <= '0;
      werrs_q <= '0;
      bcnt_q  <= '0;
      ecnt_q  <= '0;
      berr_q  <= 3'd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      wbits_q <= wbits_d;
      werrs_q <= werrs_d;
      bcnt_q  <= bcnt_d;
      ecnt_q  <= ecnt_d;
      berr_q  <= berr_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.locked    = (state_q == S_LOCK);
  assign bus.lock_lost = lost_q;
  assign bus.bit_err   = berr_q;
  assign bus.bit_count = bcnt_q;
  assign bus.err_count = ecnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_m_seq_checker.sv
// Directed bench for m_seq_checker: PRBS13 source, expected bit_err queue and
// expected lock/counter state compared after every symbol.
module tb_m_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;

  m_seq_checker_if #(.CNT_W(32)) bus ();

  m_seq_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [2:0]  exp_q[$];
  logic [12:0] gen_q = 13'h0001;
  logic        exp_locked = 1'b0;
  logic        exp_lost = 1'b0;
  logic [31:0] exp_bits = 32'd0;
  logic [31:0] exp_errs = 32'd0;
  int          exp_win = 0;
  int          exp_win_errs = 0;
  int          n_lost = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // PRBS13 source: b[n] = b[n-9]^b[n-10]^b[n-12]^b[n-13], earliest bit in the MSB used
  task automatic gen_sym(input logic m, output logic [3:0] s);
    logic b;
    s = 4'd0;
    for (int i = 0; i < (m ? 4 : 2); i++) begin
      b     = gen_q[8] ^ gen_q[9] ^ gen_q[11] ^ gen_q[12];
      gen_q = {gen_q[11:0], b};
      if (m) s[3-i] = b;
      else   s[1-i] = b;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] e;
    e = exp_q.pop_front();
    chk({tag, "_bit_err"},   {29'd0, bus.bit_err}, {29'd0, e});
    chk({tag, "_locked"},    {31'd0, bus.locked},  {31'd0, exp_locked});
    chk({tag, "_lock_lost"}, {31'd0, bus.lock_lost}, {31'd0, exp_lost});
    chk({tag, "_bit_count"}, bus.bit_count, exp_bits);
    chk({tag, "_err_count"}, bus.err_count, exp_errs);
    if (bus.lock_lost) n_lost++;
  endtask

  task automatic send(input logic m, input logic [3:0] s, input logic [2:0] nerr,
                      input logic set_lock, input logic clr);
    int nb;
    nb = m ? 4 : 2;
    bus.mod_type  = m;
    bus.sym_in    = s;
    bus.sym_valid = 1'b1;
    bus.clr_cnt   = clr;
    exp_lost      = 1'b0;
    if (exp_locked) begin
      exp_q.push_back(nerr);
      exp_bits     += nb;
      exp_errs     += {29'd0, nerr};
      exp_win      += nb;
      exp_win_errs += int'(nerr);
      if (exp_win >= 256) begin
        if (exp_win_errs >= 32) begin
          exp_locked = 1'b0;
          exp_lost   = 1'b1;
        end else begin
          exp_win      = 0;
          exp_win_errs = 0;
        end
      end
    end else begin
      exp_q.push_back(3'd0);
      if (set_lock) begin
        exp_locked   = 1'b1;
        exp_win      = 0;
        exp_win_errs = 0;
      end
    end
    if (clr) begin
      exp_bits = 32'd0;
      exp_errs = 32'd0;
    end
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
    bus.clr_cnt   = 1'b0;
    check_outputs("sym");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      exp_lost      = 1'b0;
      exp_q.push_back(3'd0);
      bus.sym_valid = 1'b0;
      bus.sym_in    = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check_outputs("idle");
    end
  endtask

  task automatic do_reset();
    bus.sym_valid = 1'b0;
    bus.clr_cnt   = 1'b0;
    bus.sym_in    = 4'd0;
    bus.mod_type  = 1'b0;
    exp_locked    = 1'b0;
    exp_lost      = 1'b0;
    exp_bits      = 32'd0;
    exp_errs      = 32'd0;
    exp_win       = 0;
    exp_win_errs  = 0;
    exp_q.delete();
    #1;
    rst = 1'b1;
    #2;
    chk("rst_locked",    {31'd0, bus.locked},    {31'd0, exp_locked});
    chk("rst_lock_lost", {31'd0, bus.lock_lost}, {31'd0, exp_lost});
    chk("rst_bit_err",   {29'd0, bus.bit_err},   32'd0);
    chk("rst_bit_count", bus.bit_count, exp_bits);
    chk("rst_err_count", bus.err_count, exp_errs);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] s;
    logic [3:0] flip;
    bus.mod_type  = 1'b0;
    bus.sym_in    = 4'd0;
    bus.sym_valid = 1'b0;
    bus.clr_cnt   = 1'b0;
    do_reset();

    // All-zero input never locks
    for (int i = 0; i < 1000; i++) send(1'b1, 4'h0, 3'd0, 1'b0, 1'b0);
    do_reset();

    // Clean 16QAM: lock on the 12th symbol, then 100 more symbols
    for (int i = 0; i < 12; i++) begin
      gen_sym(1'b1, s);
      send(1'b1, s, 3'd0, i == 11, 1'b0);
    end
    for (int i = 0; i < 100; i++) begin
      gen_sym(1'b1, s);
      send(1'b1, s, 3'd0, 1'b0, 1'b0);
    end
    chk("bits_after_100", bus.bit_count, 32'd400);

    // Single flipped bit at a random position
    flip = 4'(1 << $urandom_range(0, 3));
    gen_sym(1'b1, s);
    send(1'b1, s ^ flip, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      gen_sym(1'b1, s);
      send(1'b1, s, 3'd0, 1'b0, 1'b0);
    end
    chk("single_err", bus.err_count, 32'd1);

    // Error coincident with clr_cnt, then idle cycles
    gen_sym(1'b1, s);
    send(1'b1, s ^ 4'b0001, 3'd1, 1'b0, 1'b1);
    gen_sym(1'b1, s);
    send(1'b1, s, 3'd0, 1'b0, 1'b0);
    idle(3);

    // Inverted data: loss of lock at the next window boundary
    n_lost = 0;
    for (int i = 0; i < 64; i++) begin
      gen_sym(1'b1, s);
      send(1'b1, ~s, 3'd4, 1'b0, 1'b0);
    end
    chk("lost_pulses", n_lost, 32'd1);

    // Clean data resumes: relock on the 12th symbol
    for (int i = 0; i < 12; i++) begin
      gen_sym(1'b1, s);
      send(1'b1, s, 3'd0, i == 11, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      gen_sym(1'b1, s);
      send(1'b1, s, 3'd0, 1'b0, 1'b0);
    end

    // Reset while locked, then clean QPSK: lock on the 23rd symbol
    do_reset();
    for (int i = 0; i < 23; i++) begin
      gen_sym(1'b0, s);
      send(1'b0, s, 3'd0, i == 22, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      gen_sym(1'b0, s);
      send(1'b0, s, 3'd0, 1'b0, 1'b0);
    end

    // Mode change while locked keeps lock
    for (int i = 0; i < 10; i++) begin
      gen_sym(1'b1, s);
      send(1'b1, s, 3'd0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
